// File: rtl/weight_serial_loader.sv
// Serial weight-load transmitter: accepts weight words over a valid/ready
// handshake and shifts each one MSB-first onto a 1-bit line with a write
// strobe and word address, covering one full NUM_WEIGHTS-word load per Start.
module weight_serial_loader #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned NUM_WEIGHTS = 65,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              Start,
    input  logic [WIDTH-1:0]  WordData,
    input  logic              WordValid,
    output logic              WordReady,
    output logic              In,
    output logic              WE,
    output logic [ADDR_W-1:0] Addr,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GapW = 2;

    localparam logic [BitW-1:0]   BitLast  = BitW'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(NUM_WEIGHTS - 1);
    // Gap counter counts down to zero, so it is loaded with GAP_CYCLES-1.
    localparam logic [GapW-1:0]   GapLoad  = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StGap,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              ready_q, ready_d;
    logic              in_q, in_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state logic; all outputs are registered copies decoded from the next state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        addr_d  = addr_q;
        bit_d   = bit_q;
        gap_d   = gap_q;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StFetch;
                    count_d = '0;
                end
            end
            StFetch: begin
                // ready_q is high exactly while in StFetch, so one word per visit.
                if (WordValid && ready_q) begin
                    shift_d = WordData;
                    addr_d  = count_q;
                    bit_d   = BitLast;
                    state_d = StShift;
                end
            end
            StShift: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                bit_d   = bit_q - 1'b1;
                if (bit_q == '0) begin
                    if (count_q == LastWord) begin
                        state_d = StFin;
                    end else begin
                        count_d = count_q + 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = StFetch;
                        end else begin
                            state_d = StGap;
                            gap_d   = GapLoad;
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StFetch;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            StFin: begin
                // Start here is deliberately dropped; the source re-issues it in idle.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StFetch);
        we_d    = (state_d == StShift);
        in_d    = we_d & shift_d[WIDTH-1];
        busy_d  = (state_d == StFetch) || (state_d == StShift) || (state_d == StGap);
        done_d  = (state_d == StFin);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            count_q <= '0;
            addr_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            in_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            in_q    <= in_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign WordReady = ready_q;
    assign In        = in_q;
    assign WE        = we_q;
    assign Addr      = addr_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: doc/weight_serial_loader.md
Name: weight_serial_loader

Overview:
- Transmit end of the serial weight-load interface used by the network's weight RAMs.
- Accepts signed weight words from an upstream source (host or ROM sequencer) over a valid/ready handshake.
- Serialises each word MSB-first onto a 1-bit line with a write-enable strobe and a word address.
- A full load covers the 65-word weight map: hidden neurons at 0..49, output neurons at 50..64.

Parameters:
- WIDTH, 10, bits per weight word.
- NUM_WEIGHTS, 65, words per load sequence.
- ADDR_W, 7, address width; must satisfy 2^ADDR_W >= NUM_WEIGHTS.
- GAP_CYCLES, 1, idle cycles with WE low between consecutive words (legal range 0..3).

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Rst  input  1  synchronous, active-low reset.
- Start  input  1  single-cycle request to begin a load sequence.
- WordData  input  WIDTH  signed weight word from the source.
- WordValid  input  1  WordData is valid.
- WordReady  output  1  loader accepts WordData this cycle.
- In  output  1  serial data bit to the weight RAMs.
- WE  output  1  high while a word's bits are on In.
- Addr  output  ADDR_W  address of the word currently on In.
- Busy  output  1  load sequence in progress.
- Done  output  1  one-cycle pulse after the last bit of word NUM_WEIGHTS-1.

Behaviour:
- Reset (Rst=0 at an edge): state IDLE, all outputs 0, word counter 0, shift register 0. Reset mid-sequence aborts immediately; WE drops on the next edge and no partial word completes.
- States: IDLE, FETCH, SHIFT, GAP, FIN.
- IDLE:
  - Busy=0, WordReady=0.
  - Start=1 moves to FETCH, sets counter=0 and Busy=1 from the next cycle.
- FETCH:
  - WordReady=1, WE=0.
  - When WordValid && WordReady, latch WordData into the shift register, set Addr=counter, bit counter=WIDTH-1, go to SHIFT.
  - WordValid low just holds in FETCH with no timeout.
- SHIFT:
  - WE=1, In=shift_reg[WIDTH-1]; shift left by one each cycle.
  - Exactly WIDTH cycles with WE=1 per word; Addr stays stable throughout.
  - After the WIDTH-th bit:
    - If counter==NUM_WEIGHTS-1, go to FIN.
    - Else increment counter and go to GAP (or straight to FETCH if GAP_CYCLES=0).
- GAP:
  - WE=0, In=0, WordReady=0.
  - Hold GAP_CYCLES cycles, then go to FETCH.
- FIN:
  - Done=1 for exactly one cycle, Busy=0 in the same cycle, WE=0.
  - Return to IDLE.
- Handshake: WordReady is asserted only in FETCH and is registered (no combinational path from WordValid). At most one word is accepted per FETCH visit.
- Start while Busy=1 is ignored, with no restart. Start in the same cycle as FIN is also ignored; the source must re-issue Start in IDLE.
- Bit order and sign: MSB first, two's complement bits sent unmodified. In and WE change only on rising edges.
- Latency:
  - Word accept to first WE=1 cycle: 1 cycle.
  - Minimum per-word period: 1 (FETCH) + WIDTH + GAP_CYCLES cycles.
  - Full load with an always-valid source: NUM_WEIGHTS*(WIDTH+1+GAP_CYCLES) cycles, minus GAP_CYCLES for the final word.
- Addr holds its last value after FIN until the next Start. It resets to 0 only on reset or when the next word 0 is latched.

Test Plan:
- Reset then Start with WordData=10'sb1000000001 always valid -> first frame Addr=0, WE high 10 cycles, In sequence 1,0,0,0,0,0,0,0,0,1; WordReady high exactly one cycle before it.
- Full load with words 0..64 equal to their index (WordData=i), source always valid -> 65 frames, Addr 0..64 in order, each frame's In bits equal i MSB-first; Done pulses once, 64*12+11=779 cycles after the first accept.
- Source withholds WordValid for 5 cycles before word 7 -> loader holds in FETCH with WE=0 for those 5 cycles; word 7 then sent intact at Addr=7, and no word is skipped or duplicated.
- Word -1 (10'h3FF) and -512 (10'h200) -> In gives ten 1s; then 1 followed by nine 0s.
- Rst=0 for one cycle during bit 4 of word 20 -> WE, Busy, Addr and WordReady all 0 next cycle; a fresh Start restarts at Addr=0.
- Start pulsed again at word 30 and in the FIN cycle -> both ignored; exactly one Done and 65 frames total, and the loader stays IDLE afterwards.
